snake_motion_ctrl: RTL and testbench
====================================

Name: snake_motion_ctrl

Overview:
Parametrised, multi-player successor to the snake direction state machine. It generates the movement tick from a programmable speed level and latches per-player button commands between ticks. It applies direction rules with reverse-move rejection and a global pause/resume, and emits registered per-player directions plus a one-cycle move strobe to the game logic / painter.

Parameters:
N_PLAYERS, 2, number of independent snakes (1..4)
CNT_W, 25, tick counter width
BASE_PERIOD, 4000000, clk cycles per tick at speed 0
N_SPEEDS, 4, speed levels; period = BASE_PERIOD >> speed (BASE_PERIOD >> (N_SPEEDS-1) must be >= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  N_PLAYERS  per-player command strobe
cmd  in  3*N_PLAYERS  per-player code: 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause, 6/7 ignored
speed  in  clog2(N_SPEEDS)  speed level; values >= N_SPEEDS clamp to N_SPEEDS-1
freeze  in  1  game-over / hold: stops ticks
dir_out  out  3*N_PLAYERS  per-player registered direction, 0 idle/paused, 1..4 as cmd
move_pulse  out  1  one-clk strobe; dir_out valid this cycle
paused  out  1  global pause flag

Behaviour:
- Reset (async): counter 0; pending regs 0; all player states IDLE; global RUN; dir_out 0; move_pulse 0; paused 0.
- Tick gen: counter counts 0..P-1 with tick when count == P-1, then wraps to 0.
- Tick gen: P is recomputed from clamped speed only at wrap, so a mid-period speed change applies to the next period.
- Tick gen: freeze high holds counter at 0, no ticks, and clears pending. States and dir_out are retained. After freeze falls, the first tick comes P cycles later.
- Pending: per player, cmd_valid with code 1..5 overwrites pending (latest wins); codes 0, 6, 7 are ignored.
- Pending: on the tick cycle, the evaluation consumes the old pending and pending is cleared. A cmd_valid on that same cycle loads pending for the next tick.
- Tick evaluation: the registers below update on the clk edge ending the tick cycle. move_pulse is high for exactly one cycle after that edge (latency 1 from tick).
- pause_req = any player's pending == 5.
- Global FSM RUN, no pause_req: per player, IDLE + dir 1..4 -> that dir.
- RUN, moving + perpendicular dir -> new dir.
- RUN, moving + same or reverse dir (same axis) -> keep current dir.
- RUN, pending 0 -> keep current dir.
- RUN, no pause_req: dir_out = state, move_pulse = 1.
- RUN + pause_req -> PAUSED: states kept, other pending dirs discarded, dir_out all 0, move_pulse 0, paused = 1.
- PAUSED, no pause_req: stay PAUSED; direction commands discarded; no pulse.
- PAUSED + pause_req -> RUN: states unchanged (resume prior directions), dir_out = state, move_pulse = 1, paused = 0.
- A player still IDLE outputs 0 but move_pulse still fires in RUN.
- Reset mid-period or mid-pause returns immediately to reset values.
- freeze has priority over a tick in the same cycle.

Decomposition:
- snake_pkg: direction/command codes (DIR_NONE..DIR_RIGHT, CMD_PAUSE), global state enum (RUN, PAUSED), function same_axis(a,b).
- Sub-module snake_tick_gen: counter, speed clamp, period reload at wrap, freeze hold; outputs tick.
- Top: pending regs, per-player dir FSM (generate loop), global pause FSM, output regs.

Test Plan:
- BASE_PERIOD=16, speed=0: reset, then no commands -> move_pulse every 16 clk, dir_out=0, paused=0; first pulse 16 clk after rst falls.
- P0 cmd 4 before tick -> next pulse dir_out[P0]=4. Then cmd 3 (reverse) -> stays 4. Then cmd 1 -> 1. P1 cmds 2 then 3 within one period -> P1=3 (latest wins).
- P0 moving 4, P1 cmd 5 -> at tick paused=1, dir_out=0, no pulse. P0 cmd 1 while paused -> ignored. P1 cmd 5 -> pulse with dir_out[P0]=4, paused=0.
- speed changed 0->2 mid-period -> current period completes at 16, subsequent pulses every 4 clk. speed=7 with N_SPEEDS=4 -> period 2.
- cmd_valid asserted exactly on the tick cycle -> applied at the following tick, not the current one.
- freeze raised for 40 clk mid-period -> no pulses, dir_out held, pending cleared. After release, next pulse at 16 clk. rst pulse mid-pause -> all outputs 0, RUN.

Source files
------------

// File: rtl/snake_motion_ctrl_pkg.sv
// Shared codes, global state type and helpers for the snake motion controller.
package snake_motion_ctrl_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;
  localparam logic [2:0] CMD_PAUSE = 3'd5;

  typedef enum logic [0:0] {StRun, StPaused} gstate_e;

  // True when both codes are directions on the same axis (same or reverse move).
  function automatic logic same_axis(logic [2:0] a, logic [2:0] b);
    logic a_vert, b_vert, a_horz, b_horz;
    a_vert = (a == DIR_UP)   || (a == DIR_DOWN);
    b_vert = (b == DIR_UP)   || (b == DIR_DOWN);
    a_horz = (a == DIR_LEFT) || (a == DIR_RIGHT);
    b_horz = (b == DIR_LEFT) || (b == DIR_RIGHT);
    return (a_vert && b_vert) || (a_horz && b_horz);
  endfunction

  // Direction codes 1..4.
  function automatic logic is_dir(logic [2:0] c);
    return (c >= DIR_UP) && (c <= DIR_RIGHT);
  endfunction

  // Codes worth latching: directions and pause.
  function automatic logic is_cmd(logic [2:0] c);
    return (c >= DIR_UP) && (c <= CMD_PAUSE);
  endfunction

endpackage

// File: rtl/snake_motion_ctrl_if.sv
// Command/status bundle between the game front-end and the motion controller.
interface snake_motion_ctrl_if #(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned SPEED_W   = 2
);
  logic [N_PLAYERS-1:0]   cmd_valid;
  logic [3*N_PLAYERS-1:0] cmd;
  logic [SPEED_W-1:0]     speed;
  logic                   freeze;
  logic [3*N_PLAYERS-1:0] dir_out;
  logic                   move_pulse;
  logic                   paused;

  modport master (
    output cmd_valid, cmd, speed, freeze,
    input  dir_out, move_pulse, paused
  );

  modport slave (
    input  cmd_valid, cmd, speed, freeze,
    output dir_out, move_pulse, paused
  );
endinterface

// File: rtl/snake_motion_ctrl_tick_gen.sv
// Movement tick generator: programmable period, reloaded only at wrap, held by freeze.
module snake_motion_ctrl_tick_gen #(
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned BASE_PERIOD = 4000000,
  parameter int unsigned N_SPEEDS    = 4,
  parameter int unsigned SPEED_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_freeze,
  output logic               o_tick
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_PERIOD);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_new;
  int unsigned      w_speed_cl;

  // Clamp the requested speed and derive the period it selects.
  always_comb begin
    w_speed_cl = 32'(i_speed);
    if (w_speed_cl >= N_SPEEDS) w_speed_cl = N_SPEEDS - 1;
    w_period_new = CNT_W'(BASE_PERIOD >> w_speed_cl);
  end

  // Freeze outranks a coincident terminal count.
  assign o_tick = !i_freeze && (r_cnt == r_period - CNT_W'(1));

  // Counter and period register; freeze keeps tracking speed so release starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_period <= BASE;
    end else if (i_freeze || o_tick) begin
      r_cnt    <= '0;
      r_period <= w_period_new;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_motion_ctrl.sv
// Multi-player snake motion controller: command latching, direction rules, global pause.
module snake_motion_ctrl
  import snake_motion_ctrl_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned BASE_PERIOD = 4000000,
  parameter int unsigned N_SPEEDS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  snake_motion_ctrl_if.slave  bus
);

  localparam int unsigned SPEED_W = (N_SPEEDS > 1) ? $clog2(N_SPEEDS) : 1;

  logic                   w_tick;
  logic                   w_pause_req;
  logic [2:0]             r_pend     [N_PLAYERS];
  logic [2:0]             w_pend_d   [N_PLAYERS];
  logic [2:0]             r_dir_st   [N_PLAYERS];
  logic [2:0]             w_dir_st_d [N_PLAYERS];
  gstate_e                r_gstate;
  gstate_e                w_gstate_d;
  logic [3*N_PLAYERS-1:0] r_dir_out;
  logic [3*N_PLAYERS-1:0] w_dir_out_d;
  logic                   r_pulse;
  logic                   w_pulse_d;

  snake_motion_ctrl_tick_gen #(
    .CNT_W       (CNT_W),
    .BASE_PERIOD (BASE_PERIOD),
    .N_SPEEDS    (N_SPEEDS),
    .SPEED_W     (SPEED_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .i_speed  (bus.speed),
    .i_freeze (bus.freeze),
    .o_tick   (w_tick)
  );

  // Pause toggles when any player's latched command is pause.
  always_comb begin
    w_pause_req = 1'b0;
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      if (r_pend[i] == CMD_PAUSE) w_pause_req = 1'b1;
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [2:0] w_code;
    assign w_code = bus.cmd[3*p +: 3];

    // Pending: latest valid command wins; a tick consumes it unless refilled that cycle.
    always_comb begin
      w_pend_d[p] = r_pend[p];
      if (bus.freeze)                           w_pend_d[p] = DIR_NONE;
      else if (bus.cmd_valid[p] && is_cmd(w_code)) w_pend_d[p] = w_code;
      else if (w_tick)                          w_pend_d[p] = DIR_NONE;
    end

    // Direction: only turns while running; reversing onto the same axis is rejected.
    always_comb begin
      w_dir_st_d[p] = r_dir_st[p];
      if (w_tick && (r_gstate == StRun) && !w_pause_req && is_dir(r_pend[p])) begin
        if ((r_dir_st[p] == DIR_NONE) || !same_axis(r_dir_st[p], r_pend[p])) begin
          w_dir_st_d[p] = r_pend[p];
        end
      end
    end

    // Per-player pending and direction state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pend[p]   <= DIR_NONE;
        r_dir_st[p] <= DIR_NONE;
      end else begin
        r_pend[p]   <= w_pend_d[p];
        r_dir_st[p] <= w_dir_st_d[p];
      end
    end
  end

  // Global run/pause state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gstate  <= StRun;
      r_dir_out <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_gstate  <= w_gstate_d;
      r_dir_out <= w_dir_out_d;
      r_pulse   <= w_pulse_d;
    end
  end

  // Global next state: a pause request on a tick flips run/pause.
  always_comb begin
    w_gstate_d = r_gstate;
    if (w_tick && w_pause_req) begin
      w_gstate_d = (r_gstate == StRun) ? StPaused : StRun;
    end
  end

  // Output next values: publish directions and strobe only when running after the tick.
  always_comb begin
    w_dir_out_d = r_dir_out;
    w_pulse_d   = 1'b0;
    if (w_tick) begin
      if (w_gstate_d == StRun) begin
        w_pulse_d = 1'b1;
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
          w_dir_out_d[3*i +: 3] = w_dir_st_d[i];
        end
      end else begin
        w_dir_out_d = '0;
      end
    end
  end

  assign bus.dir_out    = r_dir_out;
  assign bus.move_pulse = r_pulse;
  assign bus.paused     = (r_gstate == StPaused);

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic
// checked every cycle against a behavioural model.
module tb_snake_motion_ctrl;

  localparam int unsigned NP = 2;
  localparam int unsigned CW = 25;
  localparam int unsigned BP = 16;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  snake_motion_ctrl_if #(.N_PLAYERS(NP), .SPEED_W(SW)) bus ();

  snake_motion_ctrl #(
    .N_PLAYERS   (NP),
    .CNT_W       (CW),
    .BASE_PERIOD (BP),
    .N_SPEEDS    (NS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_pend [NP] = '{default: 0};
  int     m_st   [NP] = '{default: 0};
  int     m_dir  [NP] = '{default: 0};
  bit     m_pz    = 0;
  bit     m_pulse = 0;
  longint m_cyc   = 0;
  longint m_t0    = 0;
  int     m_per   = BP;
  bit     m_tick, m_req;
  int     m_code;

  function automatic int period_of(int sp);
    if (sp > int'(NS) - 1) sp = int'(NS) - 1;
    return int'(BP) >> sp;
  endfunction

  // Axis index: up/down -> 0, left/right -> 1.
  function automatic int axis(int d);
    return (d - 1) / 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < int'(NP); p++) begin
        m_pend[p] = 0; m_st[p] = 0; m_dir[p] = 0;
      end
      m_pz = 0; m_pulse = 0; m_cyc = 0; m_t0 = 0; m_per = BP;
    end else begin
      m_tick = !bus.freeze && (m_cyc - m_t0 == longint'(m_per - 1));
      if (bus.freeze || m_tick) begin
        m_t0  = m_cyc + 1;
        m_per = period_of(int'(bus.speed));
      end
      m_req = 0;
      for (int p = 0; p < int'(NP); p++) if (m_pend[p] == 5) m_req = 1;
      m_pulse = 0;
      if (m_tick) begin
        if (m_req) m_pz = !m_pz;
        else if (!m_pz) begin
          for (int p = 0; p < int'(NP); p++) begin
            if (m_pend[p] >= 1 && m_pend[p] <= 4 &&
                (m_st[p] == 0 || axis(m_pend[p]) != axis(m_st[p])))
              m_st[p] = m_pend[p];
          end
        end
        m_pulse = !m_pz;
        for (int p = 0; p < int'(NP); p++) m_dir[p] = m_pz ? 0 : m_st[p];
      end
      for (int p = 0; p < int'(NP); p++) begin
        m_code = int'(bus.cmd[3*p +: 3]);
        if (bus.freeze) m_pend[p] = 0;
        else if (bus.cmd_valid[p] && m_code >= 1 && m_code <= 5) m_pend[p] = m_code;
        else if (m_tick) m_pend[p] = 0;
      end
      m_cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int p = 0; p < int'(NP); p++)
      check($sformatf("model_dir_p%0d", p), int'(bus.dir_out[3*p +: 3]), m_dir[p]);
    check("model_move_pulse", int'(bus.move_pulse), int'(m_pulse));
    check("model_paused", int'(bus.paused), int'(m_pz));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int code);
    bus.cmd_valid[p]    = 1'b1;
    bus.cmd[3*p +: 3]   = 3'(code);
    step();
    bus.cmd_valid[p]    = 1'b0;
    bus.cmd[3*p +: 3]   = 3'd0;
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.move_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_paused(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.paused) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int dir_of(input int p);
    return int'(bus.dir_out[3*p +: 3]);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    int code;
    bus.cmd_valid = '0;
    bus.cmd       = '0;
    bus.speed     = '0;
    bus.freeze    = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dir_out", int'(bus.dir_out), 0);
    check("reset_move_pulse", int'(bus.move_pulse), 0);
    check("reset_paused", int'(bus.paused), 0);
    rst = 1'b0;

    // Idle running: pulses every 16 cycles, first one 16 cycles after reset release.
    wait_pulse(40, n);
    check("first_pulse_latency", n, 16);
    check("idle_dir_out", int'(bus.dir_out), 0);
    check("idle_paused", int'(bus.paused), 0);
    wait_pulse(40, n);
    check("period_speed0", n, 16);

    // Direction rules.
    send(0, 4);
    wait_pulse(40, n);
    check("pulse_after_cmd", n, 15);
    check("p0_right", dir_of(0), 4);
    send(0, 3);
    wait_pulse(40, n);
    check("p0_reverse_rejected", dir_of(0), 4);
    send(0, 1);
    wait_pulse(40, n);
    check("p0_turn_up", dir_of(0), 1);
    send(1, 2);
    send(1, 3);
    wait_pulse(40, n);
    check("p1_latest_wins", dir_of(1), 3);
    check("p0_kept", dir_of(0), 1);

    // Pause / resume.
    send(1, 5);
    wait_paused(40, n);
    check("pause_entered", int'(bus.paused), 1);
    check("pause_dir_zero", int'(bus.dir_out), 0);
    check("pause_no_pulse", int'(bus.move_pulse), 0);
    send(0, 3);
    wait_pulse(40, n);
    check("paused_no_pulse", n, -1);
    send(1, 5);
    wait_pulse(40, n);
    check("resume_pulse_seen", int'(n > 0), 1);
    check("resume_paused", int'(bus.paused), 0);
    check("resume_p0", dir_of(0), 1);
    check("resume_p1", dir_of(1), 3);

    // Speed changes apply from the next period.
    repeat (3) step();
    bus.speed = 2'd2;
    wait_pulse(40, n);
    check("speed_change_current", n, 13);
    wait_pulse(40, n);
    check("speed2_period", n, 4);
    bus.speed = 2'd3;
    wait_pulse(40, n);
    check("speed3_current", n, 4);
    wait_pulse(40, n);
    check("speed3_period", n, 2);
    bus.speed = 2'd0;
    wait_pulse(40, n);
    check("speed0_current", n, 2);
    wait_pulse(40, n);
    check("speed0_period", n, 16);

    // Command on the tick cycle lands at the following tick.
    repeat (15) step();
    send(0, 3);
    check("tick_cycle_pulse", int'(bus.move_pulse), 1);
    check("tick_cycle_cmd_not_yet", dir_of(0), 1);
    wait_pulse(40, n);
    check("tick_cycle_next_period", n, 16);
    check("tick_cycle_cmd_applied", dir_of(0), 3);

    // Freeze: no pulses, outputs held, pending dropped, fresh period after release.
    send(0, 2);
    repeat (4) step();
    bus.freeze = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      pulses += int'(bus.move_pulse);
    end
    check("freeze_no_pulses", pulses, 0);
    check("freeze_dir_held", dir_of(0), 3);
    bus.freeze = 1'b0;
    wait_pulse(40, n);
    check("freeze_release_latency", n, 16);
    check("freeze_pending_cleared", dir_of(0), 3);

    // Reset while paused.
    send(1, 5);
    wait_paused(40, n);
    check("pause_before_reset", int'(bus.paused), 1);
    rst = 1'b1;
    #1;
    check("midreset_paused", int'(bus.paused), 0);
    check("midreset_dir", int'(bus.dir_out), 0);
    check("midreset_pulse", int'(bus.move_pulse), 0);
    step();
    rst = 1'b0;
    wait_pulse(40, n);
    check("post_reset_latency", n, 16);
    check("post_reset_dir", int'(bus.dir_out), 0);

    // Random traffic, checked against the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < int'(NP); p++) begin
        bus.cmd_valid[p] = ($urandom_range(0, 3) == 0);
        code = int'($urandom_range(0, 7));
        if (code == 5 && $urandom_range(0, 15) != 0) code = 1 + int'($urandom_range(0, 3));
        bus.cmd[3*p +: 3] = 3'(code);
      end
      if ($urandom_range(0, 40) == 0) bus.speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) bus.freeze = ~bus.freeze;
      if ($urandom_range(0, 700) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      step();
    end
    bus.cmd_valid = '0;
    bus.freeze    = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
